// File: rtl/branch_sequencer_pkg.sv
// Shared CPU definitions: branch opcode, condition codes, IR field positions
// and the branch sequencer state encoding.
package cpu_pkg;

  localparam logic [4:0] OPC_BR = 5'b10011;

  typedef enum logic [1:0] {
    BR_ZR = 2'b00,
    BR_NZ = 2'b01,
    BR_PL = 2'b10,
    BR_MI = 2'b11
  } br_cond_e;

  localparam int RA_HI = 26;
  localparam int RA_LO = 23;
  localparam int C2_HI = 20;
  localparam int C2_LO = 19;
  localparam int C_HI  = 18;

  typedef enum logic [2:0] {
    S_IDLE,
    S_READ,
    S_EVAL,
    S_SAMPLE,
    S_UPDATE
  } seq_state_e;

  function automatic logic [4:0] opcode_of(input logic [31:0] ir);
    return ir[31:27];
  endfunction

endpackage

// File: rtl/branch_sequencer_if.sv
// Bundle of the control-unit, register-file, ConFF and PC signals seen by the
// branch sequencer; slave is the sequencer's view, master the environment's.
interface branch_sequencer_if #(
  parameter int DATA_W = 32
);
  logic              start;
  logic [31:0]       ir_in;
  logic [DATA_W-1:0] pc_in;
  logic [3:0]        rf_addr;
  logic [DATA_W-1:0] rf_data;
  logic              con_in;
  logic [31:0]       con_ir;
  logic [DATA_W-1:0] con_bus;
  logic              con_ff;
  logic [DATA_W-1:0] pc_out;
  logic              pc_load;
  logic              taken;
  logic              busy;
  logic              done;
  logic              illegal;

  modport slave (
    input  start, ir_in, pc_in, rf_data, con_ff,
    output rf_addr, con_in, con_ir, con_bus, pc_out, pc_load, taken, busy,
           done, illegal
  );

  modport master (
    output start, ir_in, pc_in, rf_data, con_ff,
    input  rf_addr, con_in, con_ir, con_bus, pc_out, pc_load, taken, busy,
           done, illegal
  );
endinterface

// File: rtl/branch_target_adder.sv
// Next-PC adder: pc + 1 + sign-extended offset, modulo 2^DATA_W.
module branch_target_adder #(
  parameter int DATA_W = 32,
  parameter int C_W    = 19
) (
  input  logic [DATA_W-1:0] pc_i,
  input  logic [C_W-1:0]    offset_i,
  output logic [DATA_W-1:0] target_o
);
  logic [DATA_W-1:0] offset_sext;

  assign offset_sext = {{(DATA_W-C_W){offset_i[C_W-1]}}, offset_i};
  assign target_o    = pc_i + DATA_W'(1) + offset_sext;
endmodule

// File: rtl/branch_sequencer.sv
// Sequences a conditional branch: reads Ra, strobes the ConFF for one cycle,
// samples its registered result and issues the PC update.
module branch_sequencer
  import cpu_pkg::*;
#(
  parameter int         DATA_W = 32,
  parameter logic [4:0] OPC_BR = cpu_pkg::OPC_BR,
  parameter int         C_W    = 19
) (
  input  logic               clock,
  input  logic               clear,
  branch_sequencer_if.slave  bus
);

  seq_state_e        state_q;
  logic [31:0]       ir_q;
  logic [DATA_W-1:0] pc_q;
  logic [3:0]        rf_addr_q;
  logic              con_in_q;
  logic [31:0]       con_ir_q;
  logic [DATA_W-1:0] pc_out_q;
  logic              pc_load_q;
  logic              taken_q;
  logic              busy_q;
  logic              done_q;
  logic              illegal_q;

  logic [C_W-1:0]    offset_d;
  logic [DATA_W-1:0] target_d;

  // A not-taken branch reuses the adder with a zero offset (pc + 1).
  assign offset_d = bus.con_ff ? ir_q[C_W-1:0] : '0;

  branch_target_adder #(
    .DATA_W (DATA_W),
    .C_W    (C_W)
  ) u_target (
    .pc_i     (pc_q),
    .offset_i (offset_d),
    .target_o (target_d)
  );

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clock or negedge clear) begin
    if (!clear) begin
      state_q   <= S_IDLE;
      ir_q      <= '0;
      pc_q      <= '0;
      rf_addr_q <= '0;
      con_in_q  <= 1'b0;
      con_ir_q  <= '0;
      pc_out_q  <= '0;
      pc_load_q <= 1'b0;
      taken_q   <= 1'b0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      illegal_q <= 1'b0;
    end else begin
      con_in_q  <= 1'b0;
      pc_load_q <= 1'b0;
      done_q    <= 1'b0;
      illegal_q <= 1'b0;
      case (state_q)
        S_IDLE: begin
          if (bus.start) begin
            if (opcode_of(bus.ir_in) == OPC_BR) begin
              ir_q      <= bus.ir_in;
              pc_q      <= bus.pc_in;
              rf_addr_q <= bus.ir_in[RA_HI:RA_LO];
              busy_q    <= 1'b1;
              state_q   <= S_READ;
            end else begin
              illegal_q <= 1'b1;
            end
          end
        end
        S_READ: begin
          con_in_q <= 1'b1;
          con_ir_q <= ir_q;
          state_q  <= S_EVAL;
        end
        S_EVAL: begin
          con_ir_q <= '0;
          state_q  <= S_SAMPLE;
        end
        S_SAMPLE: begin
          // busy drops here so it is never high together with done.
          taken_q   <= bus.con_ff;
          pc_out_q  <= target_d;
          pc_load_q <= 1'b1;
          done_q    <= 1'b1;
          busy_q    <= 1'b0;
          state_q   <= S_UPDATE;
        end
        S_UPDATE: state_q <= S_IDLE;
        default:  state_q <= S_IDLE;
      endcase
    end
  end

  // rf_data only becomes valid during EVAL, so the operand is steered straight
  // through and forced to zero in every other state.
  assign bus.con_bus = (state_q == S_EVAL) ? bus.rf_data : '0;

  assign bus.rf_addr = rf_addr_q;
  assign bus.con_in  = con_in_q;
  assign bus.con_ir  = con_ir_q;
  assign bus.pc_out  = pc_out_q;
  assign bus.pc_load = pc_load_q;
  assign bus.taken   = taken_q;
  assign bus.busy    = busy_q;
  assign bus.done    = done_q;
  assign bus.illegal = illegal_q;

endmodule
